result_seg_display: RTL and testbench

- Downstream consumer of the calculator's 8-bit result (the value driven onto led).
- Converts the result to decimal with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
- Accepts a new value via a valid strobe; holds the last converted value on the display until the next conversion completes.

---
 rtl/result_seg_display.sv | 206 ++++++++++++++++++++
 tb/tb_result_seg_display.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/result_seg_display.sv
// Sequential double-dabble converter feeding a 4-digit common-anode multiplexed display.
// Optional SEG_SIGNED_EN: treat value as two's complement and show a minus sign on digit 3.
module result_seg_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value,
  input  logic       value_valid,
  output logic       busy,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = $clog2(SCAN_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state_reg, state_next;
  logic [19:0] sh_reg, sh_next, sh_adj, sh_shift;
  logic [2:0]  iter_reg, iter_next;
  logic        pend_reg, pend_next;
  logic [7:0]  pend_val_reg, pend_val_next;
  logic [3:0]  ones_reg, ones_next;
  logic [3:0]  tens_reg, tens_next;
  logic [3:0]  hund_reg, hund_next;
  logic [7:0]  load_val;
  logic        disp_neg;

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;

`ifdef SEG_SIGNED_EN
  logic conv_neg_reg, conv_neg_next;
  logic disp_neg_reg, disp_neg_next;
  assign disp_neg = disp_neg_reg;
`else
  assign disp_neg = 1'b0;
`endif

  // Conversion input: magnitude in signed mode (-128 maps to 128), raw value otherwise.
  function automatic logic [7:0] magnitude(input logic [7:0] v);
`ifdef SEG_SIGNED_EN
    return v[7] ? 8'(~v + 8'd1) : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on each BCD nibble before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign sh_adj[8+4*gi +: 4] = (sh_reg[8+4*gi +: 4] >= 4'd5) ?
                                   sh_reg[8+4*gi +: 4] + 4'd3 : sh_reg[8+4*gi +: 4];
    end
  endgenerate
  assign sh_adj[7:0] = sh_reg[7:0];
  assign sh_shift    = sh_adj << 1;

  assign load_val = value_valid ? value : pend_val_reg;

  always_comb begin
    state_next    = state_reg;
    sh_next       = sh_reg;
    iter_next     = iter_reg;
    pend_next     = pend_reg;
    pend_val_next = pend_val_reg;
    ones_next     = ones_reg;
    tens_next     = tens_reg;
    hund_next     = hund_reg;
`ifdef SEG_SIGNED_EN
    conv_neg_next = conv_neg_reg;
    disp_neg_next = disp_neg_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (value_valid) begin
          sh_next    = {12'd0, magnitude(value)};
          iter_next  = 3'd0;
          state_next = CONVERT;
`ifdef SEG_SIGNED_EN
          conv_neg_next = value[7];
`endif
        end
      end
      CONVERT: begin
        sh_next   = sh_shift;
        iter_next = iter_reg + 3'd1;
        if (value_valid) begin
          pend_next     = 1'b1;
          pend_val_next = value;
        end
        if (iter_reg == 3'd7) begin
          hund_next = sh_shift[19:16];
          tens_next = sh_shift[15:12];
          ones_next = sh_shift[11:8];
`ifdef SEG_SIGNED_EN
          disp_neg_next = conv_neg_reg;
`endif
          pend_next = 1'b0;
          // A strobe on the finishing edge is the newest value, so it wins over the stored one.
          if (value_valid || pend_reg) begin
            sh_next   = {12'd0, magnitude(load_val)};
            iter_next = 3'd0;
`ifdef SEG_SIGNED_EN
            conv_neg_next = load_val[7];
`endif
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sh_reg       <= '0;
      iter_reg     <= '0;
      pend_reg     <= 1'b0;
      pend_val_reg <= '0;
      ones_reg     <= '0;
      tens_reg     <= '0;
      hund_reg     <= '0;
`ifdef SEG_SIGNED_EN
      conv_neg_reg <= 1'b0;
      disp_neg_reg <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      sh_reg       <= sh_next;
      iter_reg     <= iter_next;
      pend_reg     <= pend_next;
      pend_val_reg <= pend_val_next;
      ones_reg     <= ones_next;
      tens_reg     <= tens_next;
      hund_reg     <= hund_next;
`ifdef SEG_SIGNED_EN
      conv_neg_reg <= conv_neg_next;
      disp_neg_reg <= disp_neg_next;
`endif
    end
  end

  // Digit select with leading-zero blanking; ones digit is always lit.
  always_comb begin
    an_next  = ~(4'b0001 << idx_reg);
    seg_next = SEG_BLANK;
    case (idx_reg)
      2'd0: seg_next = seg_code(ones_reg);
      2'd1: seg_next = (hund_reg == 4'd0 && tens_reg == 4'd0) ? SEG_BLANK : seg_code(tens_reg);
      2'd2: seg_next = (hund_reg == 4'd0) ? SEG_BLANK : seg_code(hund_reg);
      2'd3: seg_next = disp_neg ? SEG_MINUS : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      idx_reg <= 2'd0;
      an_reg  <= 4'b1111;
      seg_reg <= SEG_BLANK;
    end else begin
      if (cnt_reg == CW'(SCAN_DIV - 1)) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign busy = (state_reg == CONVERT);
  assign an   = an_reg;
  assign seg  = seg_reg;
  assign dp   = 1'b1;

endmodule

// File: tb/tb_result_seg_display.sv
// Directed bench for result_seg_display: reset, conversions, blanking, pending strobes, abort.
module tb_result_seg_display;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111, SM = 7'b0111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] value = 8'd0;
  logic       value_valid = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks = 0;
  int errors = 0;

  result_seg_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
    .busy(busy), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Waits (bounded) for digit pos to be scanned, then checks its segment pattern.
  task automatic show(input int pos, input logic [6:0] exp, input string tag);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << pos);
    n = 0;
    @(negedge clk);
    while (an !== want && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check({tag, "_an_timeout"}, 32'(an), 32'(want));
    else         check(tag, 32'(seg), 32'(exp));
  endtask

  // Drives a one-cycle strobe; returns at the negedge following the sampling edge.
  task automatic strobe(input logic [7:0] v);
    value = v;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic convert(input logic [7:0] v, input logic [6:0] h, input logic [6:0] t,
                         input logic [6:0] o, input logic [6:0] d3, input string tag);
    strobe(v);
    check({tag, "_busy_n"}, 32'(busy), 32'd1);
    repeat (7) @(negedge clk);
    check({tag, "_busy_n7"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_busy_n8"}, 32'(busy), 32'd0);
    show(0, o,  {tag, "_ones"});
    show(1, t,  {tag, "_tens"});
    show(2, h,  {tag, "_hund"});
    show(3, d3, {tag, "_d3"});
  endtask

  function automatic logic [6:0] seg_for_200(input logic [3:0] a);
    case (a)
      4'b1110: return S0;
      4'b1101: return S0;
      4'b1011: return S2;
      default: return SB;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'(SB));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("scan0_an", 32'(an), 32'hE);
    check("scan0_seg", 32'(seg), 32'(S0));
    show(1, SB, "scan1_blank");
    show(2, SB, "scan2_blank");
    show(3, SB, "scan3_blank");

    convert(8'd157, S1, S5, S7, SB, "v157");
    convert(8'd7,   SB, SB, S7, SB, "v7");
    convert(8'd40,  SB, S4, S0, SB, "v40");

    // Pending: 200 at N, 12 at N+3, 99 at N+5; 12 is overwritten.
    strobe(8'd200);
    repeat (2) @(negedge clk);
    strobe(8'd12);
    @(negedge clk);
    strobe(8'd99);
    repeat (3) @(negedge clk);
    check("pend_busy_n8", 32'(busy), 32'd1);
    for (int k = 9; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("pend_busy_n%0d", k), 32'(busy), (k == 16) ? 32'd0 : 32'd1);
      check($sformatf("pend_seg200_n%0d", k), 32'(seg), 32'(seg_for_200(an)));
    end
    show(0, S9, "pend99_ones");
    show(1, S9, "pend99_tens");
    show(2, SB, "pend99_hund");

    // Reset at N+4 during conversion of 255.
    strobe(8'd255);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_an", 32'(an), 32'hF);
    @(negedge clk);
    check("abort_ones", 32'(seg), 32'(S0));
    show(1, SB, "abort_tens");
    convert(8'd255, S2, S5, S5, SB, "v255");

`ifdef SEG_SIGNED_EN
    convert(8'hFD, SB, SB, S3, SM, "sfd");
    convert(8'h80, S1, S2, S8, SM, "s80");
    convert(8'd5,  SB, SB, S5, SB, "s05");
`else
    convert(8'hFD, S2, S5, S3, SB, "ufd");
    convert(8'h80, S1, S2, S8, SB, "u80");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
